// File: rtl/deathinfo_ctrl.sv
// Death / game-over / restart sequencer: freezes play on death, shows the game-over overlay,
// blinks the retry-key highlight and issues a one-cycle restart request on a fresh key press.
module deathinfo_ctrl #(
   parameter int unsigned DEATH_DELAY_FRAMES = 60,
   parameter int unsigned MIN_SHOW_FRAMES    = 30,
   parameter int unsigned BLINK_HALF_FRAMES  = 30,
   parameter logic [7:0]  RESTART_KEY        = 8'h15
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       player_dead,
   input  logic [7:0] keycode,
   output logic       freeze_game,
   output logic       show_screen,
   output logic       blink_on,
   output logic       restart_pulse,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StPlay    = 3'd0,
      StDying   = 3'd1,
      StShow    = 3'd2,
      StArmed   = 3'd3,
      StRestart = 3'd4
   } state_e;

   localparam logic [7:0] DeathLast = 8'(DEATH_DELAY_FRAMES - 1);
   localparam logic [7:0] ShowLast  = 8'(MIN_SHOW_FRAMES - 1);
   localparam logic [7:0] BlinkLast = 8'(BLINK_HALF_FRAMES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       blink_q, blink_d;
   logic       frame_clk_q;
   logic       frame_valid_q;
   logic       key_match_q;
   logic       key_match;
   logic       frame_tick;
   logic       key_edge;

   // frame_valid_q blocks a tick until frame_clk has really been sampled low after reset.
   assign frame_tick = frame_clk & ~frame_clk_q & frame_valid_q;
   assign key_match  = (keycode == RESTART_KEY);
   assign key_edge   = key_match & ~key_match_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= StPlay;
         cnt_q         <= 8'd0;
         blink_q       <= 1'b0;
         frame_clk_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         key_match_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         blink_q       <= blink_d;
         frame_clk_q   <= frame_clk;
         frame_valid_q <= 1'b1;
         key_match_q   <= key_match;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blink_d = 1'b0;
      case (state_q)
         StPlay: begin
            if (player_dead) begin
               state_d = StDying;
               cnt_d   = 8'd0;
            end
         end
         StDying: begin
            if (frame_tick) begin
               if (cnt_q == DeathLast) begin
                  state_d = StShow;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StShow: begin
            if (frame_tick) begin
               if (cnt_q == ShowLast) begin
                  state_d = StArmed;
                  cnt_d   = 8'd0;
                  blink_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StArmed: begin
            blink_d = blink_q;
            // A key press outranks a coincident frame tick: nothing else updates.
            if (key_edge) begin
               state_d = StRestart;
            end else if (frame_tick) begin
               if (cnt_q == BlinkLast) begin
                  blink_d = ~blink_q;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StRestart: begin
            state_d = StPlay;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = StPlay;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      freeze_game   = (state_q != StPlay);
      show_screen   = (state_q == StShow) || (state_q == StArmed);
      blink_on      = blink_q && (state_q == StArmed);
      restart_pulse = (state_q == StRestart);
      state         = state_q;
   end

endmodule

// File: tb/tb_deathinfo_ctrl.sv
// Randomised bench for deathinfo_ctrl, checked every cycle against a phase/tick-count model.
module tb_deathinfo_ctrl;

   localparam int          Death = 60;
   localparam int          Show  = 30;
   localparam int          Blink = 30;
   localparam logic [7:0]  RKey  = 8'h15;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       player_dead;
   logic [7:0] keycode;
   logic       freeze_game, show_screen, blink_on, restart_pulse;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   // Reference model: phase uses the published state numbering.
   int m_phase;
   int m_ticks;
   int m_armed;
   bit m_prev_fc;
   bit m_fc_valid;
   bit m_prev_km;

   // frame_clk generator
   bit fc_level = 1'b0;
   int fc_hold  = 3;

   deathinfo_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .player_dead   (player_dead),
      .keycode       (keycode),
      .freeze_game   (freeze_game),
      .show_screen   (show_screen),
      .blink_on      (blink_on),
      .restart_pulse (restart_pulse),
      .state         (state)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      bit exp_blink;
      exp_blink = (m_phase == 3) && (((m_armed / Blink) % 2) == 0);
      check_eq({tag, ".state"},   8'(state),         8'(m_phase));
      check_eq({tag, ".freeze"},  8'(freeze_game),   8'(m_phase != 0));
      check_eq({tag, ".show"},    8'(show_screen),   8'(m_phase == 2 || m_phase == 3));
      check_eq({tag, ".blink"},   8'(blink_on),      8'(exp_blink));
      check_eq({tag, ".restart"}, 8'(restart_pulse), 8'(m_phase == 4));
   endtask

   task automatic model_reset();
      m_phase    = 0;
      m_ticks    = 0;
      m_armed    = 0;
      m_prev_fc  = 1'b0;
      m_fc_valid = 1'b0;
      m_prev_km  = 1'b0;
   endtask

   task automatic model_apply(input bit fc, input bit pd, input logic [7:0] kc);
      bit tick, km, kedge;
      tick  = fc && m_fc_valid && !m_prev_fc;
      km    = (kc == RKey);
      kedge = km && !m_prev_km;
      case (m_phase)
         0: if (pd) begin m_phase = 1; m_ticks = 0; end
         1: if (tick) begin
               m_ticks++;
               if (m_ticks == Death) begin m_phase = 2; m_ticks = 0; end
            end
         2: if (tick) begin
               m_ticks++;
               if (m_ticks == Show) begin m_phase = 3; m_ticks = 0; m_armed = 0; end
            end
         3: if (kedge) m_phase = 4;
            else if (tick) m_armed++;
         default: m_phase = 0;
      endcase
      m_prev_fc  = fc;
      m_fc_valid = 1'b1;
      m_prev_km  = km;
   endtask

   task automatic gen_fc(output bit fc);
      if (fc_hold == 0) begin
         fc_level = ~fc_level;
         fc_hold  = $urandom_range(3, 6);
      end else begin
         fc_hold--;
      end
      fc = fc_level;
   endtask

   task automatic step_fc(input bit fc, input bit pd, input logic [7:0] kc);
      @(negedge Clk);
      frame_clk   = fc;
      player_dead = pd;
      keycode     = kc;
      model_apply(fc, pd, kc);
      @(posedge Clk);
      #1;
      check_outputs("cyc");
   endtask

   task automatic step(input bit pd, input logic [7:0] kc);
      bit fc;
      gen_fc(fc);
      step_fc(fc, pd, kc);
   endtask

   function automatic logic [7:0] idle_key();
      logic [7:0] k;
      k = 8'($urandom_range(0, 255));
      if (k == RKey) k = 8'h00;
      return k;
   endfunction

   // Runs until the model reaches the target phase; the DUT state is then compared.
   task automatic run_until(input int target, input bit pd, input logic [7:0] kc, input int budget);
      int n = 0;
      while (m_phase != target && n < budget) begin
         step(pd, kc);
         n++;
      end
      check_eq("reach_state", 8'(state), 8'(target));
   endtask

   task automatic do_reset(input bit pd);
      player_dead = pd;
      Reset       = 1'b0;
      #1;
      model_reset();
      check_outputs("rst");
      repeat (2) @(posedge Clk);
      #1;
      check_outputs("rst_hold");
      Reset = 1'b1;
   endtask

   initial begin
      logic [7:0] cur_kc;
      Reset       = 1'b1;
      frame_clk   = 1'b0;
      player_dead = 1'b0;
      keycode     = 8'h00;
      model_reset();
      #1;
      do_reset(1'b0);

      // Death pulse through show, 90+ armed ticks of blinking, then a restart.
      repeat (3) step(1'b0, idle_key());
      step(1'b1, 8'h00);
      run_until(2, 1'b0, 8'h00, 2000);
      run_until(3, 1'b0, 8'h00, 1000);
      begin
         int n = 0;
         while (m_armed < 95 && n < 2000) begin step(1'b0, idle_key()); n++; end
      end
      step(1'b0, RKey);
      step(1'b0, RKey);
      step(1'b0, 8'h00);

      // Key held from dying into armed must not restart; a re-press does.
      step(1'b1, 8'h00);
      run_until(3, 1'b0, RKey, 3000);
      repeat (40) step(1'b0, RKey);
      repeat (5) step(1'b0, 8'h00);
      run_until(4, 1'b0, RKey, 10);
      repeat (3) step(1'b0, RKey);

      // A press during show is ignored; only the later press restarts.
      step(1'b1, 8'h00);
      run_until(2, 1'b0, 8'h00, 2000);
      repeat (4) step(1'b0, RKey);
      repeat (4) step(1'b0, 8'h00);
      run_until(3, 1'b0, 8'h00, 1000);
      repeat (10) step(1'b0, 8'h00);
      run_until(4, 1'b0, RKey, 10);
      repeat (3) step(1'b0, 8'h00);

      // Key edge landing on the frame tick that would toggle the blink.
      step(1'b1, 8'h00);
      run_until(3, 1'b0, 8'h00, 3000);
      begin
         int n = 0;
         bit fc;
         while (m_phase == 3 && n < 2000) begin
            gen_fc(fc);
            if (fc && !m_prev_fc && (m_armed % Blink) == Blink - 1) step_fc(fc, 1'b0, RKey);
            else step_fc(fc, 1'b0, 8'h00);
            n++;
         end
         check_eq("collide_restart", 8'(state), 8'd4);
      end
      repeat (3) step(1'b0, 8'h00);

      // Reset at dying tick 20 with player_dead still high.
      step(1'b1, 8'h00);
      begin
         int n = 0;
         while (m_ticks < 20 && n < 1000) begin step(1'b1, 8'h00); n++; end
      end
      do_reset(1'b1);
      repeat (5) step(1'b1, 8'h00);
      repeat (20) step(1'b0, idle_key());

      // Random traffic.
      cur_kc = 8'h00;
      for (int i = 0; i < 7000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0:       cur_kc = 8'h00;
               1:       cur_kc = RKey;
               default: cur_kc = idle_key();
            endcase
         end
         if ($urandom_range(0, 1999) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            step($urandom_range(0, 59) == 0, cur_kc);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/deathinfo_ctrl.md
DEATHINFO_CTRL -- requirements
Module: deathinfo_ctrl

Interface
REQ-001 SHALL have parameter DEATH_DELAY_FRAMES, default 60, frames of frozen play between death and game-over screen (legal 1..255).
REQ-002 SHALL have parameter MIN_SHOW_FRAMES, default 30, frames the screen is shown before the restart key is accepted (legal 1..255).
REQ-003 SHALL have parameter BLINK_HALF_FRAMES, default 30, frames per half-period of the retry-key highlight blink (legal 1..255).
REQ-004 SHALL have parameter RESTART_KEY, default 8'h15, USB HID keycode of the restart key ('R').
REQ-005 Clk  input  1  system clock; the only clock.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 frame_clk  input  1  vertical-sync-rate strobe, synchronous to Clk, level-type (high for many Clk cycles).
REQ-008 player_dead  input  1  level from game logic, high while the player is dead.
REQ-009 keycode  input  8  current pressed keycode, 8'h00 when none.
REQ-010 freeze_game  output  1  high when the game world stops updating.
REQ-011 show_screen  output  1  high when the renderer selects the game-over text overlay.
REQ-012 blink_on  output  1  high when the retry-key letter is drawn in its highlight colour.
REQ-013 restart_pulse  output  1  single-Clk-cycle request to reinitialise the level.
REQ-014 state  output  3  current FSM encoding, for debug.

Function
REQ-015 SHALL generate frame_tick, a one-Clk-cycle pulse on each rising edge of frame_clk, using a registered previous value of frame_clk.
REQ-016 SHALL generate key_edge, a one-cycle pulse when (keycode == RESTART_KEY) is true this cycle and was false the previous cycle; a key already held on ARMED entry SHALL NOT produce key_edge.
REQ-017 SHALL implement FSM states PLAY=3'd0, DYING=3'd1, SHOW=3'd2, ARMED=3'd3, RESTART=3'd4; encodings 5..7 SHALL transition to PLAY on the next cycle.
REQ-018 PLAY: player_dead high -> DYING next cycle, frame counter cleared to 0.
REQ-019 DYING: counter increments on each frame_tick; frame_tick with counter == DEATH_DELAY_FRAMES-1 -> SHOW, counter cleared.
REQ-020 SHOW: counter increments on frame_tick; frame_tick with counter == MIN_SHOW_FRAMES-1 -> ARMED, counter cleared; key_edge in SHOW SHALL be ignored.
REQ-021 ARMED: key_edge -> RESTART next cycle; otherwise counter increments on frame_tick and on frame_tick with counter == BLINK_HALF_FRAMES-1, blink_on toggles and counter clears.
REQ-022 ARMED with key_edge and frame_tick in the same cycle: key_edge SHALL win; blink_on and counter SHALL NOT update.
REQ-023 RESTART: restart_pulse = 1 for exactly this one cycle; next state PLAY, counter cleared.
REQ-024 player_dead SHALL be ignored in every state except PLAY; player_dead still high on return to PLAY SHALL re-enter DYING on the next cycle.
REQ-025 Frame counter SHALL be 8 bits and SHALL never wrap in normal operation, since every compare terminates below 255.
REQ-026 freeze_game = (state != PLAY); show_screen = (state == SHOW or ARMED); both SHALL be combinational from registered state.
REQ-027 blink_on SHALL be set to 1 on entry to ARMED and SHALL be forced to 0 in every other state.
REQ-028 restart_pulse SHALL be combinational from state == RESTART and SHALL not depend on any input.
REQ-029 Each state transition SHALL take exactly one Clk edge after its qualifying condition.

Reset
REQ-030 Reset low SHALL immediately force state=PLAY, counter=0, blink_on=0, previous frame_clk=0, previous key-match=0; resulting outputs freeze_game=0, show_screen=0, restart_pulse=0.
REQ-031 Reset asserted in any state, including mid-DYING or mid-RESTART, SHALL abort the sequence with no restart_pulse emitted.
REQ-032 After Reset release, the first frame_tick SHALL require an observed 0->1 transition of frame_clk.

Verification
REQ-033 Default parameters, player_dead pulse in PLAY -> freeze_game=1 next cycle; show_screen=1 one cycle after the 60th frame_tick.
REQ-034 Hold keycode=8'h15 continuously from DYING through ARMED -> no restart_pulse; release then press again in ARMED -> restart_pulse high exactly one cycle, state=PLAY the cycle after.
REQ-035 Press 'R' during SHOW (before the 30th tick), release, press after ARMED entry -> only the second press restarts.
REQ-036 In ARMED for 90 ticks with no key -> blink_on sequence 1,0,1,0 changing after ticks 30, 60, 90.
REQ-037 key_edge coincident with frame_tick at a blink boundary -> RESTART taken, blink_on holds, then 0 in RESTART.
REQ-038 Reset asserted mid-DYING (tick 20) and player_dead held high -> PLAY during reset, DYING one cycle after release, counter restarts at 0.
